serial_alu_ctrl: RTL

Bit-serial sequencer that time-shares one external single-bit full adder cell to perform WIDTH-bit add/subtract. It accepts operands through a start/ready handshake and presents one bit pair plus carry to the full adder per cycle, LSB first. It captures the cell's sum, carry-out and propagate outputs, then delivers the result, carry, overflow, zero and all-propagate flags with a one-cycle done pulse. It sits between the ALU control logic and the shared full adder datapath cell.

---
 rtl/serial_alu_ctrl.sv | 112 +++++++++++
 1 files changed

// File: rtl/serial_alu_ctrl.sv
// serial_alu_ctrl: bit-serial add/subtract sequencer that time-shares one
// external single-bit full adder cell, LSB first, one bit per cycle.
module serial_alu_ctrl #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             op,
  input  logic [WIDTH-1:0] op_a,
  input  logic [WIDTH-1:0] op_b,
  output logic             ready,
  output logic             fa_a,
  output logic             fa_b,
  output logic             fa_cin,
  input  logic             fa_sum,
  input  logic             fa_cout,
  input  logic             fa_p,
  output logic [WIDTH-1:0] result,
  output logic             cout,
  output logic             ovf,
  output logic             zero,
  output logic             all_p,
  output logic             done
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state;
  logic [WIDTH-1:0] a_sh;
  logic [WIDTH-1:0] b_sh;
  // Holds the WIDTH-1 sum bits captured so far; the final bit comes straight
  // from the cell on the last edge, so the full sum is {fa_sum, sum_sh}.
  logic [WIDTH-2:0] sum_sh;
  logic [CW-1:0]    cnt;
  logic             carry;
  logic             msb_cin;
  logic             p_acc;

  logic             last;
  logic [WIDTH-1:0] sum_fin;
  logic             msb_cin_now;

  assign last        = (cnt == CW'(WIDTH - 1));
  assign sum_fin     = {fa_sum, sum_sh};
  // On the last bit the carry into the MSB is the current carry register.
  assign msb_cin_now = last ? carry : msb_cin;

  // Status decoded directly from the state register.
  assign ready  = (state == IDLE);
  assign done   = (state == DONE);

  // Cell operands are forced low whenever the cell is not in use.
  assign fa_a   = (state == RUN) & a_sh[0];
  assign fa_b   = (state == RUN) & b_sh[0];
  assign fa_cin = (state == RUN) & carry;

  // Sequencer: operand capture, per-bit shift/carry update, result load.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      a_sh    <= '0;
      b_sh    <= '0;
      sum_sh  <= '0;
      cnt     <= '0;
      carry   <= 1'b0;
      msb_cin <= 1'b0;
      p_acc   <= 1'b0;
      result  <= '0;
      cout    <= 1'b0;
      ovf     <= 1'b0;
      zero    <= 1'b0;
      all_p   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            a_sh  <= op_a;
            b_sh  <= op ? ~op_b : op_b;
            carry <= op;
            cnt   <= '0;
            p_acc <= 1'b1;
            state <= RUN;
          end
        end
        RUN: begin
          sum_sh <= sum_fin[WIDTH-1:1];
          a_sh   <= a_sh >> 1;
          b_sh   <= b_sh >> 1;
          carry  <= fa_cout;
          p_acc  <= p_acc & fa_p;
          if (last) begin
            msb_cin <= carry;
            result  <= sum_fin;
            cout    <= fa_cout;
            ovf     <= msb_cin_now ^ fa_cout;
            zero    <= (sum_fin == '0);
            all_p   <= p_acc & fa_p;
            state   <= DONE;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        DONE: state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule
